// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a registered carry, one bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sa_reg, sa_next;
    logic [WIDTH-1:0]   sb_reg, sb_next;
    logic [WIDTH-2:0]   psum_reg, psum_next;
    logic [WIDTH-2:0]   psum_shifted;
    logic               carry_reg, carry_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   o_reg, o_next;
    logic               cout_reg, cout_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_reg, ovf_next;
`endif
    logic               fa_s;
    logic               fa_c;

    assign fa_s = sa_reg[0] ^ sb_reg[0] ^ carry_reg;
    assign fa_c = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & carry_reg) | (sb_reg[0] & carry_reg);

    // The partial sum holds only WIDTH-1 bits; the final bit comes straight from the slice.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 2; gi++) begin : g_psum_shift
            assign psum_shifted[gi] = psum_reg[gi+1];
        end
    endgenerate
    assign psum_shifted[WIDTH-2] = fa_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            psum_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            o_reg     <= '0;
            cout_reg  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            psum_reg  <= psum_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            o_reg     <= o_next;
            cout_reg  <= cout_next;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        psum_next  = psum_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        o_next     = o_reg;
        cout_next  = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_next   = ovf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sa_next    = a;
                    sb_next    = b;
                    carry_next = cin;
                    cnt_next   = '0;
                    psum_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                carry_next = fa_c;
                psum_next  = psum_shifted;
                sa_next    = sa_reg >> 1;
                sb_next    = sb_reg >> 1;
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    o_next     = {fa_s, psum_reg};
                    cout_next  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_reg is the carry into the MSB on this last step
                    ovf_next   = carry_reg ^ fa_c;
`endif
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign o    = o_reg;
    assign cout = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule
